// File: rtl/inv_sqrt_seed_if.sv
// Start/done bundle between the fastInvSqrt controller and the seed stage.
// Handshake (four-phase request/acknowledge): the master raises start with x
// valid and holds both until done is seen high; the slave raises done with
// x_half/y0/zero_in valid and holds them until start drops, then clears done
// on the following edge. Results stay valid until the next accepted start.
interface inv_sqrt_seed_if #(parameter int W = 16) ();
  logic         start;
  logic [W-1:0] x;
  logic         done;
  logic [W-1:0] x_half;
  logic [W-1:0] y0;
  logic         zero_in;

  modport master (output start, output x,
                  input  done, input x_half, input y0, input zero_in);
  modport slave  (input  start, input x,
                  output done, output x_half, output y0, output zero_in);
endinterface

// File: rtl/inv_sqrt_seed.sv
// Seed stage of the fast inverse square root: normalises x one bit per cycle,
// then derives x/2 and a coarse 1/sqrt(x) estimate from the exponent parity
// and the top fraction bits of the normalised mantissa.
module inv_sqrt_seed #(
  parameter int INT_WIDTH   = 12,
  parameter int FRACT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  inv_sqrt_seed_if.slave       bus,
  output logic [1:0]           dbg_state
);
  localparam int W   = INT_WIDTH + FRACT_WIDTH;
  localparam int IW  = W + 2;
  localparam int LZW = $clog2(W + 1);
  localparam logic [IW-1:0] ONE_W = IW'(1) << FRACT_WIDTH;

  typedef enum logic [1:0] {IDLE, NORM, SEED, DONE} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   sreg_q, sreg_d;
  logic [LZW-1:0] lz_q, lz_d;
  logic           zflag_q, zflag_d;
  logic           done_q, done_d;
  logic [W-1:0]   x_half_q, x_half_d;
  logic [W-1:0]   y0_q, y0_d;
  logic           zero_in_q, zero_in_d;

  // seed datapath signals
  int              p_i, e_i, k_i, r_i;
  logic [IW-1:0]   m_w, s_w, y_w;
  logic [2*IW-1:0] wide_w;
  logic            ovf_w;
  logic [W-1:0]    seed_y;

  // Seed from the normalised operand: exponent split into k (shift) and parity r.
  always_comb begin
    p_i    = (W - 1) - int'(lz_q);
    e_i    = p_i - FRACT_WIDTH;
    k_i    = e_i >>> 1;
    r_i    = e_i - 2 * k_i;
    m_w    = IW'(sreg_q[W-2 -: FRACT_WIDTH]);
    s_w    = ONE_W - (m_w >> 2);
    wide_w = '0;
    ovf_w  = 1'b0;
    y_w    = '0;
    seed_y = '0;
    if (r_i != 0) begin
      s_w = s_w - (s_w >> 2);
    end
    if (k_i >= 0) begin
      y_w = s_w >> k_i;
    end else begin
      // a left shift that pushes set bits past the output width saturates
      wide_w = (2 * IW)'(s_w) << (-k_i);
      ovf_w  = |wide_w[2*IW-1:W];
      y_w    = wide_w[IW-1:0];
    end
    if (ovf_w) begin
      seed_y = '1;
    end else if (y_w[W-1:0] == '0) begin
      seed_y = W'(1);
    end else begin
      seed_y = y_w[W-1:0];
    end
  end

  // Next-state and datapath updates for the IDLE/NORM/SEED/DONE sequence.
  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    lz_d      = lz_q;
    zflag_d   = zflag_q;
    done_d    = done_q;
    x_half_d  = x_half_q;
    y0_d      = y0_q;
    zero_in_d = zero_in_q;
    unique case (state_q)
      IDLE: begin
        done_d = 1'b0;
        if (bus.start) begin
          sreg_d = bus.x;
          lz_d   = '0;
          if (bus.x == '0) begin
            zflag_d = 1'b1;
            state_d = SEED;
          end else begin
            zflag_d = 1'b0;
            state_d = NORM;
          end
        end
      end
      NORM: begin
        if (sreg_q[W-1]) begin
          state_d = SEED;
        end else begin
          sreg_d = sreg_q << 1;
          lz_d   = lz_q + LZW'(1);
        end
      end
      SEED: begin
        if (zflag_q) begin
          y0_d      = '1;
          x_half_d  = '0;
          zero_in_d = 1'b1;
        end else begin
          y0_d      = seed_y;
          // undo the normalisation shift to recover x, then halve it
          x_half_d  = (sreg_q >> lz_q) >> 1;
          zero_in_d = 1'b0;
        end
        done_d  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (!bus.start) begin
          done_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sreg_q    <= '0;
      lz_q      <= '0;
      zflag_q   <= 1'b0;
      done_q    <= 1'b0;
      x_half_q  <= '0;
      y0_q      <= '0;
      zero_in_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      lz_q      <= lz_d;
      zflag_q   <= zflag_d;
      done_q    <= done_d;
      x_half_q  <= x_half_d;
      y0_q      <= y0_d;
      zero_in_q <= zero_in_d;
    end
  end

  assign bus.done    = done_q;
  assign bus.x_half  = x_half_q;
  assign bus.y0      = y0_q;
  assign bus.zero_in = zero_in_q;
  assign dbg_state   = state_q;
endmodule

// File: tb/tb_inv_sqrt_seed.sv
// Directed bench for inv_sqrt_seed with INT_WIDTH=12, FRACT_WIDTH=4.
module tb_inv_sqrt_seed;
  localparam int IW_P = 12;
  localparam int FW_P = 4;
  localparam int W    = IW_P + FW_P;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;

  inv_sqrt_seed_if #(.W(W)) bus ();

  inv_sqrt_seed #(.INT_WIDTH(IW_P), .FRACT_WIDTH(FW_P)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // scoreboard of expected results for the operation in flight
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_h_q[$];
  logic         exp_z_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: y0 ~ 1/sqrt(x) from plain integer arithmetic on the value of x.
  function automatic void model(input logic [W-1:0] xv, output logic [W-1:0] y,
                                output logic [W-1:0] h, output logic z, output int lat);
    int p, e, k, r;
    longint m, s, yv;
    p = 0;
    if (xv == 0) begin
      y = '1; h = '0; z = 1'b1; lat = 2;
      return;
    end
    for (int i = 0; i < W; i++) if (xv[i]) p = i;
    lat = (W - 1 - p) + 3;
    e = p - FW_P;
    k = (e >= 0) ? e / 2 : -((1 - e) / 2);
    r = e - 2 * k;
    // fraction of the mantissa (value in [0,1)) quantised to FW_P bits
    m = ((longint'(xv) - (longint'(1) << p)) * (longint'(1) << FW_P)) / (longint'(1) << p);
    s = (longint'(1) << FW_P) - m / 4;
    if (r == 1) s = s - s / 4;
    if (k >= 0) yv = s / (longint'(1) << k);
    else        yv = s * (longint'(1) << (-k));
    if (yv > (longint'(1) << W) - 1) yv = (longint'(1) << W) - 1;
    if (yv == 0) yv = 1;
    y = yv[W-1:0];
    h = xv / 2;
    z = 1'b0;
  endfunction

  // compare process: every cycle done is high the outputs must match the model
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'(bus.done), 32'(0));
      end else begin
        chk("y0",      32'(bus.y0),      32'(exp_q[0]));
        chk("x_half",  32'(bus.x_half),  32'(exp_h_q[0]));
        chk("zero_in", 32'(bus.zero_in), 32'(exp_z_q[0]));
      end
    end
  end

  // driver: one full start/done transaction. lit_y/lit_lat < 0 means no literal.
  task automatic run_op(input logic [W-1:0] xv, input int hold, input bit toggle_x,
                        input int lit_y, input int lit_lat);
    logic [W-1:0] ey, eh;
    logic         ez;
    int           elat, edges;
    bit           seen;
    model(xv, ey, eh, ez, elat);
    exp_q.push_back(ey); exp_h_q.push_back(eh); exp_z_q.push_back(ez);
    @(negedge clk);
    bus.x = xv;
    bus.start = 1'b1;
    edges = 0;
    seen = 1'b0;
    while (!seen && edges < 100) begin
      @(posedge clk); #1;
      edges++;
      if (bus.done) seen = 1'b1;
      else if (toggle_x) bus.x = W'($urandom_range(0, 65535));
    end
    chk("done_seen", 32'(seen), 32'(1));
    chk("latency", 32'(edges), 32'(elat));
    if (lit_lat >= 0) chk("latency_literal", 32'(edges), 32'(lit_lat));
    if (lit_y >= 0)   chk("y0_literal", 32'(bus.y0), 32'(lit_y));
    repeat (hold) begin
      @(posedge clk); #1;
      chk("done_hold", 32'(bus.done), 32'(1));
    end
    bus.start = 1'b0;
    @(posedge clk); #1;
    chk("done_drop", 32'(bus.done), 32'(0));
    chk("y0_after_drop", 32'(bus.y0), 32'(ey));
    void'(exp_q.pop_front()); void'(exp_h_q.pop_front()); void'(exp_z_q.pop_front());
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.x = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_done",    32'(bus.done),    32'(0));
    chk("rst_y0",      32'(bus.y0),      32'(0));
    chk("rst_x_half",  32'(bus.x_half),  32'(0));
    chk("rst_zero_in", 32'(bus.zero_in), 32'(0));
    rst_n = 1'b1;

    run_op(16'h0010, 0, 1'b0, 16'h0010, 14);
    chk("x_half_1p0", 32'(bus.x_half), 32'h0008);
    run_op(16'h0040, 0, 1'b0, 16'h0008, -1);
    run_op(16'h0020, 0, 1'b0, 16'h000C, -1);
    run_op(16'h0060, 0, 1'b0, 16'h0007, -1);
    run_op(16'h0001, 0, 1'b0, 16'h0040, -1);
    run_op(16'h0004, 0, 1'b0, 16'h0020, -1);
    run_op(16'hFFF0, 0, 1'b0, 16'h0001, 3);
    chk("x_half_fff0", 32'(bus.x_half), 32'h7FF8);
    run_op(16'h1234, 0, 1'b0, -1, -1);
    run_op(16'h0003, 1, 1'b0, -1, -1);
    run_op(16'h8000, 0, 1'b0, -1, 3);
    run_op(16'h0000, 5, 1'b0, 16'hFFFF, 2);
    chk("zero_in_lit", 32'(bus.zero_in), 32'(1));

    // reset in the middle of normalisation
    @(negedge clk);
    bus.x = 16'h0100;
    bus.start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.start = 1'b0;
    @(posedge clk); #1;
    chk("midrst_done",    32'(bus.done),    32'(0));
    chk("midrst_y0",      32'(bus.y0),      32'(0));
    chk("midrst_x_half",  32'(bus.x_half),  32'(0));
    chk("midrst_zero_in", 32'(bus.zero_in), 32'(0));
    rst_n = 1'b1;

    // first operation after reset, with x changing while busy
    run_op(16'h0040, 2, 1'b1, 16'h0008, 12);
    run_op(16'h0004, 0, 1'b1, 16'h0020, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
